dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the CPU data load/store port. It accepts one request at a time from the core over a valid/ready handshake and performs byte, halfword or word accesses with RV32I `funct3` semantics. Load data is returned sign- or zero-extended after a fixed read latency. It sits between the core's ALU/register-file datapath (address = ALU result, write data = rs2) and a byte-lane data RAM, and replaces the plain combinational data memory.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data word width; only 32 is supported.
- `ADDR_WIDTH`, 12: byte-address bits decoded; memory is 2^ADDR_WIDTH bytes.
- `READ_LATENCY`, 2: cycles from the load acceptance edge to `rsp_valid`; legal range 1–7.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_funct3` in 3: access size and extension.
- `req_wdata` in 32: store data, taken from the low bytes.
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: request faulted. Qualified by `rsp_valid`.

## Operation
- FSM states: IDLE, LOAD_WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, the request is latched.
  - Good store: goes to RESP.
  - Good load: goes to LOAD_WAIT.
  - Faulted request: goes to RESP with the error flag set.
- LOAD_WAIT: a 3-bit counter counts READ_LATENCY-1 cycles, then the FSM goes to RESP. With READ_LATENCY=1 the FSM goes directly to RESP.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE. There is no response backpressure; the core stalls on `req_ready`.
- `funct3` values:
  - 000 = LB/SB
  - 001 = LH/SH
  - 010 = LW/SW
  - 100 = LBU
  - 101 = LHU
  - 100/101 with `req_we`=1, and 011/110/111, are faults.
- Faults, flagged with `rsp_err`=1: illegal funct3; halfword at an odd address; word with `addr[1:0]`≠0; `addr[31:ADDR_WIDTH]`≠0.
  - A fault performs no RAM write.
  - A fault returns `rsp_rdata`=0.
- Byte order is little-endian. Store byte enables:
  - SB: lane `addr[1:0]`.
  - SH: lanes {`addr[1]`*2, +1}.
  - SW: all four lanes.
  - Write data is replicated to the selected lanes.
- Loads: the selected byte or half is shifted to bit 0. LB/LH sign-extend; LBU/LHU zero-extend.
- The RAM write is committed on the acceptance edge. A following load of the same address returns the new data.
- RAM contents are not reset. Simulation initialises them to 0.

## Timing
- Reset values:
  - state = IDLE
  - `req_ready`=1 (visible in the cycle after the reset edge)
  - `rsp_valid`=0
  - `rsp_rdata`=0
  - `rsp_err`=0
  - counter = 0
- Acceptance edge is T. Responses:
  - Store or fault: `rsp_valid` in cycle T+1.
  - Load: `rsp_valid` in cycle T+READ_LATENCY.
- `req_ready`=0 from the acceptance edge until the RESP cycle. It returns to 1 in the cycle after RESP, so the minimum spacing between accepts is latency+1 cycles.
- Input changes while `req_ready`=0 are ignored. Request fields are sampled only on the acceptance edge.
- `rsp_rdata` and `rsp_err` hold their values only during the RESP cycle and are 0 otherwise.
- `rst` asserted in any state takes effect on the next edge:
  - FSM goes to IDLE.
  - Any pending response is dropped.
  - An already-accepted store stays written.
  - `rst` has priority over acceptance on the same edge.

## Structure
- Package `dmem_pkg`:
  - `funct3` localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state enum `dmem_state_t`.
  - A byte-enable function and a load-extend function.
- Sub-module `dmem_ram`: a 2^(ADDR_WIDTH-2) × 32 synchronous RAM with a 4-bit byte-write enable and a registered read port. It is addressed by `addr[ADDR_WIDTH-1:2]`.
- The responder holds the FSM, the latch registers, fault checks, lane steering and extension.

## Test plan
- SW 0xDEADBEEF @0x010, then LW @0x010 (READ_LATENCY=2) -> store `rsp_valid` at T+1, `rsp_err`=0; load `rsp_valid` exactly 2 cycles after its accept, `rsp_rdata`=0xDEADBEEF.
- SB 0x80 @0x013, then LB @0x013 and LBU @0x013 -> LB returns 0xFFFFFF80, LBU returns 0x00000080, other bytes of word 0x010 unchanged.
- SH 0x8001 @0x022, then LH @0x022 and LHU @0x022 -> LH returns 0xFFFF8001, LHU returns 0x00008001; LW @0x020 returns 0x8001_0000 (lanes 0/1 were 0).
- LW @0x011, SH @0x021, LW @0x1000, funct3=011 -> each gives `rsp_err`=1 and `rsp_rdata`=0 at T+1, RAM unchanged; `req_valid` held high across all four gives each accept ≥2 cycles apart.
- `rst` pulsed in the cycle after a load accept -> no `rsp_valid` ever appears for that load; `req_ready`=1 in the cycle after the reset edge, all outputs 0.
- Back-to-back loads with `req_valid` constantly high -> `rsp_valid` pulses exactly one cycle each; `req_ready` low for READ_LATENCY cycles per request.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_pkg: funct3 codes, FSM state type and lane steering helpers for dmem_responder.
//   byte_en   : 4-bit store byte enable from funct3 and addr[1:0]
//   store_rep : store data replicated across the selected lanes
//   load_ext  : selected byte/half shifted to bit 0 and sign/zero-extended
package dmem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} dmem_state_t;

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        return f3[1:0] == 2'b00 ? 4'b0001 << off :
               f3[1:0] == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic [31:0] store_rep(input logic [2:0] f3, input logic [31:0] wd);
        return f3[1:0] == 2'b00 ? {4{wd[7:0]}} :
               f3[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
    endfunction

    // f3[2] set means unsigned (LBU/LHU), so it suppresses the sign bit.
    function automatic logic [31:0] load_ext(input logic [31:0] q, input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] s;
        s = q >> {off, 3'b000};
        return f3[1:0] == 2'b00 ? {{24{~f3[2] & s[7]}}, s[7:0]} :
               f3[1:0] == 2'b01 ? {{16{~f3[2] & s[15]}}, s[15:0]} : s;
    endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core-to-data-memory request/response bundle.
//   req_valid/req_ready handshake with req_we, req_addr, req_funct3, req_wdata;
//   rsp_valid one-cycle strobe with rsp_rdata and rsp_err.
//   master = core side, slave = memory responder side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder_ram.sv
// dmem_ram: word-organised synchronous RAM with per-byte write enable and registered read.
//   clk, en (read strobe), we[3:0] (byte lanes), addr (word index), wdata, rdata (registered).
//   rdata holds its value until the next en, so it stays stable through the load wait.
module dmem_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        if (en) rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with RV32I byte/half/word load-store semantics.
//   clk, rst (sync, active-high), bus (dmem_responder_if.slave).
//   Stores and faults respond one cycle after acceptance; loads after READ_LATENCY cycles.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);
    dmem_state_t     state;
    logic [2:0]      cnt;
    logic            ready;
    logic            valid;
    logic            err;
    logic            ld_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic            accept;
    logic            illegal;
    logic            fault;
    logic [3:0]      ram_we;
    logic [DATA_WIDTH-1:0] ram_q;

    assign accept  = state == IDLE && bus.req_valid;
    assign illegal = !(bus.req_funct3 == F3_B || bus.req_funct3 == F3_H || bus.req_funct3 == F3_W ||
                       (!bus.req_we && (bus.req_funct3 == F3_BU || bus.req_funct3 == F3_HU)));
    assign fault   = illegal ||
                     (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                     (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
                     |bus.req_addr[31:ADDR_WIDTH];
    assign ram_we  = accept && bus.req_we && !fault ? byte_en(bus.req_funct3, bus.req_addr[1:0]) : 4'b0000;

    dmem_ram #(.AW(ADDR_WIDTH - 2), .DW(DATA_WIDTH)) u_ram (
        .clk   (clk),
        .en    (accept),
        .we    (ram_we),
        .addr  (bus.req_addr[ADDR_WIDTH-1:2]),
        .wdata (store_rep(bus.req_funct3, bus.req_wdata)),
        .rdata (ram_q)
    );

    // A load skips LOAD_WAIT when the RAM's own register stage already meets the latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            ready <= 1'b1;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    f3_q  <= bus.req_funct3;
                    off_q <= bus.req_addr[1:0];
                    ld_q  <= !fault && !bus.req_we;
                    err   <= fault;
                    ready <= 1'b0;
                    cnt   <= 3'd0;
                    if (fault || bus.req_we || READ_LATENCY == 1) begin
                        state <= RESP;
                        valid <= 1'b1;
                    end else begin
                        state <= LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(READ_LATENCY - 2)) begin
                        state <= RESP;
                        valid <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    err   <= 1'b0;
                    ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = valid;
    assign bus.rsp_err   = err;
    assign bus.rsp_rdata = valid && ld_q ? load_ext(ram_q, f3_q, off_q) : 32'h0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (READ_LATENCY = 2).
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    dmem_responder_if bus ();

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .READ_LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns just after a negedge with the block idle again.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input int lat, input logic [31:0] rd, input logic er,
                          input logic hold);
        int n;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_funct3 = f3;
        bus.req_wdata  = wd;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) check({tag, "_ready_to"}, bus.req_ready, 1);
        @(posedge clk);
        // Garbage while busy must be ignored (a stray SW to 0x010 would corrupt later reads).
        #1;
        bus.req_we     = 1'b1;
        bus.req_addr   = 32'h10;
        bus.req_funct3 = 3'b010;
        bus.req_wdata  = 32'h12345678;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.req_ready) check({tag, "_busy_ready"}, bus.req_ready, 0);
        end while (!bus.rsp_valid && n < 20);
        check({tag, "_lat"}, n, lat);
        check({tag, "_rdata"}, bus.rsp_rdata, rd);
        check({tag, "_err"}, bus.rsp_err, er);
        bus.req_valid = hold;
        @(negedge clk);
        check({tag, "_after"}, {bus.rsp_valid, bus.rsp_err, bus.req_ready, bus.rsp_rdata[28:0]}, 32'h20000000);
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_funct3 = f3;
    endtask

    initial begin
        int seen;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_funct3 = 3'b000;
        bus.req_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", bus.req_ready, 1);
        check("rst_valid", bus.rsp_valid, 0);
        check("rst_rdata", bus.rsp_rdata, 0);
        check("rst_err",   bus.rsp_err, 0);

        do_req("sw010",  1, 32'h010, 3'b010, 32'hDEADBEEF, 1, 32'h0,        0, 0);
        do_req("lw010",  0, 32'h010, 3'b010, 32'h0,        2, 32'hDEADBEEF, 0, 0);
        do_req("sb013",  1, 32'h013, 3'b000, 32'h12345680, 1, 32'h0,        0, 0);
        do_req("lb013",  0, 32'h013, 3'b000, 32'h0,        2, 32'hFFFFFF80, 0, 0);
        do_req("lbu013", 0, 32'h013, 3'b100, 32'h0,        2, 32'h00000080, 0, 0);
        do_req("lw010b", 0, 32'h010, 3'b010, 32'h0,        2, 32'h80ADBEEF, 0, 0);
        do_req("sw020",  1, 32'h020, 3'b010, 32'h0,        1, 32'h0,        0, 0);
        do_req("sh022",  1, 32'h022, 3'b001, 32'hABCD8001, 1, 32'h0,        0, 0);
        do_req("lh022",  0, 32'h022, 3'b001, 32'h0,        2, 32'hFFFF8001, 0, 0);
        do_req("lhu022", 0, 32'h022, 3'b101, 32'h0,        2, 32'h00008001, 0, 0);
        do_req("lw020",  0, 32'h020, 3'b010, 32'h0,        2, 32'h80010000, 0, 0);

        do_req("f_lw011",  0, 32'h011,  3'b010, 32'h0,      1, 32'h0, 1, 1);
        do_req("f_sh021",  1, 32'h021,  3'b001, 32'hFFFF,   1, 32'h0, 1, 1);
        do_req("f_lw1000", 0, 32'h1000, 3'b010, 32'h0,      1, 32'h0, 1, 1);
        do_req("f_f3_011", 0, 32'h010,  3'b011, 32'h0,      1, 32'h0, 1, 1);
        do_req("f_sbu",    1, 32'h020,  3'b100, 32'hFFFFFFFF, 1, 32'h0, 1, 1);
        do_req("f_lh023",  0, 32'h023,  3'b001, 32'h0,      1, 32'h0, 1, 0);
        do_req("lw010c", 0, 32'h010, 3'b010, 32'h0, 2, 32'h80ADBEEF, 0, 0);
        do_req("lw020b", 0, 32'h020, 3'b010, 32'h0, 2, 32'h80010000, 0, 0);

        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h010;
        bus.req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rr_ready", bus.req_ready, 1);
        check("rr_outs", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata[29:0]}, 32'h0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("rr_no_rsp", seen, 0);

        do_req("bb_lw",  0, 32'h010, 3'b010, 32'h0, 2, 32'h80ADBEEF, 0, 1);
        do_req("bb_lb",  0, 32'h010, 3'b000, 32'h0, 2, 32'hFFFFFFEF, 0, 1);
        do_req("bb_lhu", 0, 32'h010, 3'b101, 32'h0, 2, 32'h0000BEEF, 0, 1);
        do_req("bb_lh",  0, 32'h012, 3'b001, 32'h0, 2, 32'hFFFF80AD, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
